// File: rtl/jogo_memoria_rodadas.sv
// Memory-game core: the player replays a stored sequence of one-hot key presses,
// one more position per round, with a per-play timeout and multi-hot rejection.
module jogo_memoria_rodadas #(
  parameter int N_CHAVES = 4,
  parameter int DEPTH    = 16,
  parameter int TIMEOUT  = 5000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       iniciar,
  input  logic [N_CHAVES-1:0]        chaves,
  input  logic                       mem_we,
  input  logic [$clog2(DEPTH)-1:0]   mem_addr,
  input  logic [N_CHAVES-1:0]        mem_data,
  output logic                       acertou,
  output logic                       errou,
  output logic                       timeout,
  output logic                       pronto,
  output logic [N_CHAVES-1:0]        leds,
  output logic [$clog2(DEPTH+1)-1:0] db_rodada,
  output logic [$clog2(DEPTH)-1:0]   db_contagem,
  output logic [N_CHAVES-1:0]        db_memoria,
  output logic [N_CHAVES-1:0]        db_jogada,
  output logic [3:0]                 db_estado
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARA       = 4'h1,
    ESPERA_JOGADA = 4'h2,
    REGISTRA      = 4'h3,
    COMPARA       = 4'h4,
    PROX_POS      = 4'h5,
    PROX_RODADA   = 4'h6,
    ESPERA_SOLTA  = 4'h7,
    FIM_ACERTO    = 4'hA,
    FIM_TIMEOUT   = 4'hD,
    FIM_ERRO      = 4'hE
  } estado_t;

  estado_t             estado_q, estado_d;
  logic [RW-1:0]       rodada_q, rodada_d;
  logic [AW-1:0]       contagem_q, contagem_d;
  logic [N_CHAVES-1:0] jogada_q, jogada_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                tecla_ant_q, tecla_ant_d;
  logic                acertou_q, acertou_d;
  logic                errou_q, errou_d;
  logic                timeout_q, timeout_d;
  logic                pronto_q, pronto_d;

  logic [N_CHAVES-1:0] mem [DEPTH];
  logic [N_CHAVES-1:0] memoria;
  logic                em_repouso;
  logic                borda_jogada;
  logic                ultima_pos;

  assign memoria      = mem[contagem_q];
  assign em_repouso   = (estado_q == INICIAL) || (estado_q == FIM_ACERTO) ||
                        (estado_q == FIM_ERRO) || (estado_q == FIM_TIMEOUT);
  // A play is only the rising edge of "any key pressed"; holding keys yields one play.
  assign borda_jogada = (|chaves) && !tecla_ant_q;
  assign ultima_pos   = (RW'(contagem_q) == (rodada_q - RW'(1)));

  always_ff @(posedge clock) begin
    if (mem_we && em_repouso && (32'(mem_addr) < DEPTH)) begin
      mem[mem_addr] <= mem_data;
    end
  end

  always_comb begin
    estado_d    = estado_q;
    rodada_d    = rodada_q;
    contagem_d  = contagem_q;
    jogada_d    = jogada_q;
    timer_d     = '0;
    tecla_ant_d = |chaves;
    case (estado_q)
      INICIAL, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
        if (iniciar) begin
          estado_d   = PREPARA;
          rodada_d   = RW'(1);
          contagem_d = '0;
          jogada_d   = '0;
        end
      end
      PREPARA:      estado_d = ESPERA_SOLTA;
      ESPERA_SOLTA: if (chaves == '0) estado_d = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        timer_d = timer_q + 1'b1;
        if (borda_jogada)                      estado_d = REGISTRA;
        else if (timer_q == TW'(TIMEOUT - 1))  estado_d = FIM_TIMEOUT;
      end
      REGISTRA: begin
        jogada_d = chaves;
        estado_d = COMPARA;
      end
      COMPARA: begin
        if (!$onehot(jogada_q) || (jogada_q != memoria)) estado_d = FIM_ERRO;
        else if (!ultima_pos)                            estado_d = PROX_POS;
        else if (rodada_q == RW'(DEPTH))                 estado_d = FIM_ACERTO;
        else                                             estado_d = PROX_RODADA;
      end
      PROX_POS: begin
        contagem_d = contagem_q + 1'b1;
        estado_d   = ESPERA_SOLTA;
      end
      PROX_RODADA: begin
        rodada_d   = rodada_q + 1'b1;
        contagem_d = '0;
        estado_d   = ESPERA_SOLTA;
      end
      default: estado_d = INICIAL;
    endcase
    // Flags are registered from the next state so they line up with db_estado.
    acertou_d = (estado_d == FIM_ACERTO);
    timeout_d = (estado_d == FIM_TIMEOUT);
    errou_d   = (estado_d == FIM_ERRO) || (estado_d == FIM_TIMEOUT);
    pronto_d  = acertou_d || errou_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q    <= INICIAL;
      rodada_q    <= RW'(1);
      contagem_q  <= '0;
      jogada_q    <= '0;
      timer_q     <= '0;
      tecla_ant_q <= 1'b0;
      acertou_q   <= 1'b0;
      errou_q     <= 1'b0;
      timeout_q   <= 1'b0;
      pronto_q    <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      rodada_q    <= rodada_d;
      contagem_q  <= contagem_d;
      jogada_q    <= jogada_d;
      timer_q     <= timer_d;
      tecla_ant_q <= tecla_ant_d;
      acertou_q   <= acertou_d;
      errou_q     <= errou_d;
      timeout_q   <= timeout_d;
      pronto_q    <= pronto_d;
    end
  end

  assign acertou     = acertou_q;
  assign errou       = errou_q;
  assign timeout     = timeout_q;
  assign pronto      = pronto_q;
  assign leds        = chaves;
  assign db_rodada   = rodada_q;
  assign db_contagem = contagem_q;
  assign db_memoria  = memoria;
  assign db_jogada   = jogada_q;
  assign db_estado   = estado_q;

endmodule

// File: tb/tb_jogo_memoria_rodadas.sv
// Bench for jogo_memoria_rodadas: directed and random games checked against a
// game-level model of the expected outcome plus per-cycle output consistency.
module tb_jogo_memoria_rodadas;

  localparam int N = 4;
  localparam int D = 4;
  localparam int T = 20;

  logic         clock = 1'b0;
  logic         reset, iniciar, mem_we;
  logic [N-1:0] chaves, mem_data;
  logic [1:0]   mem_addr;
  logic         acertou, errou, timeout, pronto;
  logic [N-1:0] leds, db_memoria, db_jogada;
  logic [2:0]   db_rodada;
  logic [1:0]   db_contagem;
  logic [3:0]   db_estado;

  jogo_memoria_rodadas #(.N_CHAVES(N), .DEPTH(D), .TIMEOUT(T)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .acertou(acertou), .errou(errou), .timeout(timeout), .pronto(pronto),
    .leds(leds), .db_rodada(db_rodada), .db_contagem(db_contagem),
    .db_memoria(db_memoria), .db_jogada(db_jogada), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int           vectors = 0;
  int           miscompares = 0;
  bit           chk_on = 0;
  int           force_dly = -1;
  logic [N-1:0] model_mem [D];
  logic [N-1:0] plays [$];
  int           exp_res, exp_rod, exp_cnt;
  logic [N-1:0] exp_jog;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_on && !reset) begin
      chk("leds_echo", leds, chaves);
      chk("pronto_or", pronto, acertou | errou);
      chk("acertou_state", acertou, db_estado == 4'hA);
      chk("errou_state", errou, (db_estado == 4'hE) || (db_estado == 4'hD));
      chk("timeout_state", timeout, db_estado == 4'hD);
      chk("db_memoria", db_memoria, model_mem[db_contagem]);
      chk("contagem_bound", (db_contagem < db_rodada) && (db_rodada <= D), 1);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (db_estado == s) begin
        ok = 1;
        break;
      end
      step();
    end
    if (!ok) chk("wait_state", db_estado, s);
  endtask

  task automatic load_mem(input logic [N-1:0] w0, w1, w2, w3);
    logic [N-1:0] w [D];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int a = 0; a < D; a++) begin
      mem_we = 1'b1; mem_addr = 2'(a); mem_data = w[a];
      step();
      model_mem[a] = w[a];
    end
    mem_we = 1'b0;
    chk_on = 1;
  endtask

  function automatic logic [N-1:0] rand_word();
    logic [N-1:0] v;
    if ($urandom_range(0, 7) == 0) v = N'($urandom_range(1, 15));
    else v = N'(1) << $urandom_range(0, N - 1);
    return v;
  endfunction

  // Expected outcome of a game: replay round by round until the first bad play.
  task automatic build_game(input int er, input int ep, input int kind, input logic [N-1:0] wkey);
    bit done = 0;
    logic [N-1:0] key;
    plays.delete();
    exp_jog = '0;
    for (int r = 1; r <= D && !done; r++) begin
      for (int p = 0; p < r && !done; p++) begin
        if (r == er && p == ep && kind == 2) begin
          plays.push_back('0);
          exp_res = 2; exp_rod = r; exp_cnt = p; done = 1;
        end else begin
          key = (r == er && p == ep) ? wkey : model_mem[p];
          plays.push_back(key);
          exp_jog = key;
          if ($countones(key) != 1 || key != model_mem[p]) begin
            exp_res = 1; exp_rod = r; exp_cnt = p; done = 1;
          end
        end
      end
    end
    if (!done) begin
      exp_res = 0; exp_rod = D; exp_cnt = D - 1;
    end
  endtask

  task automatic start_game();
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    chk("start_estado", db_estado, 4'h1);
    chk("start_pronto", pronto, 0);
    chk("start_rodada", db_rodada, 1);
    chk("start_jogada", db_jogada, 0);
  endtask

  task automatic do_play(input logic [N-1:0] key, input bit last);
    bit ok;
    int dly;
    wait_state(4'h2, 200, ok);
    if (!ok) return;
    if (force_dly >= 0) dly = force_dly;
    else dly = ($urandom_range(0, 7) == 0) ? T - 1 : $urandom_range(0, 4);
    repeat (dly) step();
    // Writes and starts attempted mid-play must be ignored.
    chaves = key; mem_we = 1'b1; mem_addr = 2'($urandom_range(0, 3));
    mem_data = N'($urandom_range(0, 15)); iniciar = 1'b1;
    step();
    step();
    mem_we = 1'b0; iniciar = 1'b0;
    if (last) chk("latency_early", pronto, 0);
    step();
    if (last) chk("latency", pronto, 1);
    repeat ($urandom_range(0, 7)) step();
    chaves = '0;
  endtask

  task automatic do_idle();
    bit ok;
    wait_state(4'h2, 200, ok);
    if (!ok) return;
    repeat (T - 1) step();
    chk("pre_timeout_estado", db_estado, 4'h2);
    step();
    chk("timeout_estado", db_estado, 4'hD);
  endtask

  task automatic run_game(input int er, input int ep, input int kind, input logic [N-1:0] wkey);
    logic [3:0] code;
    build_game(er, ep, kind, wkey);
    start_game();
    for (int i = 0; i < plays.size(); i++) begin
      if (plays[i] == '0) do_idle();
      else do_play(plays[i], i == plays.size() - 1);
    end
    code = (exp_res == 0) ? 4'hA : (exp_res == 1) ? 4'hE : 4'hD;
    repeat (3) step();
    chk("end_estado", db_estado, code);
    chk("end_acertou", acertou, exp_res == 0);
    chk("end_errou", errou, exp_res != 0);
    chk("end_timeout", timeout, exp_res == 2);
    chk("end_pronto", pronto, 1);
    chk("end_rodada", db_rodada, exp_rod);
    chk("end_contagem", db_contagem, exp_cnt);
    chk("end_jogada", db_jogada, exp_jog);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int er, ep;
    reset = 1'b1; iniciar = 1'b0; mem_we = 1'b0; chaves = '0;
    mem_addr = '0; mem_data = '0;
    step(); step();
    reset = 1'b0;
    chaves = 4'b0101;
    chk("rst_estado", db_estado, 0);
    chk("rst_pronto", pronto, 0);
    chk("rst_acertou", acertou, 0);
    chk("rst_errou", errou, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_rodada", db_rodada, 1);
    chk("rst_contagem", db_contagem, 0);
    chk("rst_jogada", db_jogada, 0);
    chk("rst_leds", leds, 4'b0101);
    chaves = '0;

    // Full correct game.
    load_mem(4'd1, 4'd2, 4'd4, 4'd8);
    run_game(0, 0, 0, '0);
    chk("lit_win_estado", db_estado, 4'hA);
    chk("lit_win_rodada", db_rodada, 4);

    // Wrong key in round 3, every play on the last timer cycle.
    force_dly = T - 1;
    run_game(3, 2, 1, 4'd8);
    force_dly = -1;
    chk("lit_err_errou", errou, 1);
    chk("lit_err_timeout", timeout, 0);
    chk("lit_err_jogada", db_jogada, 4'd8);
    chk("lit_err_estado", db_estado, 4'hE);
    chk("lit_err_rodada", db_rodada, 3);

    // Multi-hot play rejected even when it matches memory.
    load_mem(4'b0011, 4'd2, 4'd4, 4'd8);
    run_game(0, 0, 0, '0);
    chk("lit_multihot_errou", errou, 1);
    chk("lit_multihot_estado", db_estado, 4'hE);

    // Timeout at round 2 position 1.
    load_mem(4'd1, 4'd2, 4'd4, 4'd8);
    run_game(2, 1, 2, '0);
    chk("lit_tmo_flags", {errou, timeout, pronto}, 3'b111);
    chk("lit_tmo_estado", db_estado, 4'hD);

    // Reset in round 2, then memory must still hold the sequence.
    start_game();
    do_play(4'd1, 0);
    do_play(4'd1, 0);
    wait_state(4'h2, 200, ok);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_estado", db_estado, 0);
    chk("midrst_flags", {acertou, errou, timeout, pronto}, 0);
    chk("midrst_rodada", db_rodada, 1);
    chk("midrst_contagem", db_contagem, 0);
    chk("midrst_memoria", db_memoria, 4'd1);
    run_game(0, 0, 0, '0);
    chk("lit_after_rst_estado", db_estado, 4'hA);

    for (int g = 0; g < 30; g++) begin
      load_mem(rand_word(), rand_word(), rand_word(), rand_word());
      er = $urandom_range(0, D);
      ep = (er > 0) ? $urandom_range(0, er - 1) : 0;
      run_game(er, ep, $urandom_range(1, 2), N'($urandom_range(1, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
